// File: rtl/ram_stream_reader.sv
// ---------------------------------------------------------------------------
// ram_stream_reader
//
// Reads a contiguous, wrapping address window from port B of the register-bank
// dual-port SRAM and emits it as a byte stream with valid/ready backpressure.
// The window can optionally be replayed until aborted (waveform playback).
// With a sink that never stalls, the block sustains one beat per clock.
//
// Ports:
//   aclk         clock, shared with the SRAM port B clock
//   areset_n     synchronous, active-low reset
//   start_i      single-cycle start request, sampled only in IDLE
//   abort_i      stop immediately; wins over start_i
//   loop_i       replay the window until aborted (sampled with start_i)
//   base_i       first address of the window (sampled with start_i)
//   len_i        window length in bytes, 0..2**G_ADDR_WIDTH (sampled with start_i)
//   busy_o       high from an accepted start until completion or abort
//   done_o       one-cycle pulse when a non-loop run completes
//   mem_adr_o    SRAM port B address
//   mem_rd_o     SRAM port B read strobe; data returns exactly one cycle later
//   mem_dat_i    SRAM port B read data
//   m_tvalid     stream beat valid
//   m_tready     sink ready
//   m_tdata      stream data
//   m_tlast      final beat of each pass through the window
//   dbg_state_o  current FSM state (0 IDLE, 1 RUN, 2 DRAIN)
//
// Stream handshake: a beat transfers on every rising edge where m_tvalid and
// m_tready are both high. Once m_tvalid is raised, m_tdata and m_tlast hold
// their values until the beat transfers; only abort or reset withdraws it.
// ---------------------------------------------------------------------------
module ram_stream_reader #(
  parameter int G_ADDR_WIDTH = 10,
  parameter int G_DATA_WIDTH = 8
) (
  input  logic                    aclk,
  input  logic                    areset_n,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic                    loop_i,
  input  logic [G_ADDR_WIDTH-1:0] base_i,
  input  logic [G_ADDR_WIDTH:0]   len_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [G_ADDR_WIDTH-1:0] mem_adr_o,
  output logic                    mem_rd_o,
  input  logic [G_DATA_WIDTH-1:0] mem_dat_i,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [G_DATA_WIDTH-1:0] m_tdata,
  output logic                    m_tlast,
  output logic [1:0]              dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [G_ADDR_WIDTH-1:0] C_ADDR_ONE = {{(G_ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [G_ADDR_WIDTH:0]   C_CNT_ONE  = {{G_ADDR_WIDTH{1'b0}}, 1'b1};

  // Control state
  state_t                  r_state;
  logic                    r_busy;
  logic                    r_done;
  logic [G_ADDR_WIDTH-1:0] r_base;
  logic [G_ADDR_WIDTH:0]   r_len;
  logic                    r_loop;
  logic [G_ADDR_WIDTH-1:0] r_rd_addr;
  logic [G_ADDR_WIDTH:0]   r_rd_cnt;

  // Read issued last cycle; its data is on mem_dat_i this cycle
  logic                    r_inflight;
  logic                    r_inflight_last;

  // Two-entry output buffer
  logic [G_DATA_WIDTH-1:0] r_fifo_dat [0:1];
  logic                    r_fifo_last [0:1];
  logic                    r_wr_ptr;
  logic                    r_rd_ptr;
  logic [1:0]              r_count;

  logic                    w_pop;
  logic                    w_push;
  logic [2:0]              w_credit;
  logic                    w_issue;
  logic [G_ADDR_WIDTH:0]   w_len_m1;
  logic                    w_last_issue;
  logic                    w_last_pop;

  assign m_tvalid = (r_count != 2'd0);
  assign m_tdata  = r_fifo_dat[r_rd_ptr];
  assign m_tlast  = r_fifo_last[r_rd_ptr] & m_tvalid;

  assign w_pop  = m_tvalid & m_tready;
  assign w_push = r_inflight;

  // Slots that will be committed after this edge: buffered + returning - leaving.
  // A pop implies a non-empty buffer, so the subtraction never underflows.
  // Issuing only while this is below 2 is what keeps the buffer from overflowing
  // while still allowing one read per cycle when the sink keeps up.
  assign w_credit = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue  = (r_state == ST_RUN) && (w_credit < 3'd2);

  assign w_len_m1     = r_len - C_CNT_ONE;
  assign w_last_issue = (r_rd_cnt == w_len_m1);
  assign w_last_pop   = w_pop & m_tlast;

  assign mem_rd_o    = w_issue;
  assign mem_adr_o   = r_rd_addr;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign dbg_state_o = r_state;

  // -------------------------------------------------------------------------
  // FSM, read counters and in-flight tracking
  // -------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      r_state         <= ST_IDLE;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_base          <= '0;
      r_len           <= '0;
      r_loop          <= 1'b0;
      r_rd_addr       <= '0;
      r_rd_cnt        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else if (abort_i) begin
      // Dropping r_inflight makes the read returning next cycle vanish
      r_state         <= ST_IDLE;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_done          <= 1'b0;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue & w_last_issue;

      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            if (len_i == '0) begin
              // Empty window: complete at once without touching the SRAM
              r_done <= 1'b1;
            end else begin
              r_base    <= base_i;
              r_len     <= len_i;
              r_loop    <= loop_i;
              r_rd_addr <= base_i;
              r_rd_cnt  <= '0;
              r_busy    <= 1'b1;
              r_state   <= ST_RUN;
            end
          end
        end

        ST_RUN: begin
          if (w_issue) begin
            if (w_last_issue) begin
              if (r_loop) begin
                r_rd_addr <= r_base;
                r_rd_cnt  <= '0;
              end else begin
                r_state <= ST_DRAIN;
              end
            end else begin
              r_rd_addr <= r_rd_addr + C_ADDR_ONE;
              r_rd_cnt  <= r_rd_cnt + C_CNT_ONE;
            end
          end
        end

        ST_DRAIN: begin
          // Only the final beat of the window carries last in non-loop runs
          if (w_last_pop) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output buffer: captures each returning read with its last flag
  // -------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      r_fifo_dat[0]  <= '0;
      r_fifo_dat[1]  <= '0;
      r_fifo_last[0] <= 1'b0;
      r_fifo_last[1] <= 1'b0;
      r_wr_ptr       <= 1'b0;
      r_rd_ptr       <= 1'b0;
      r_count        <= 2'd0;
    end else if (abort_i) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo_dat[r_wr_ptr]  <= mem_dat_i;
        r_fifo_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_ram_stream_reader
//
// Directed bench for ram_stream_reader. A behavioural SRAM (one-cycle read
// latency) is preloaded with f(addr). A table of non-loop runs is applied in a
// loop; hand-written sequences cover zero length, backpressure, loop + abort,
// start while busy and reset mid-run. A negedge monitor checks every beat
// against an expected queue and every read address against the window.
// ---------------------------------------------------------------------------
module tb_ram_stream_reader;

  localparam int AW = 10;
  localparam int DW = 8;

  logic          aclk = 1'b0;
  logic          areset_n;
  logic          start_i;
  logic          abort_i;
  logic          loop_i;
  logic [AW-1:0] base_i;
  logic [AW:0]   len_i;
  logic          busy_o;
  logic          done_o;
  logic [AW-1:0] mem_adr_o;
  logic          mem_rd_o;
  logic [DW-1:0] mem_dat_i;
  logic          m_tvalid;
  logic          m_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic [1:0]    dbg_state_o;

  ram_stream_reader #(.G_ADDR_WIDTH(AW), .G_DATA_WIDTH(DW)) dut (
    .aclk        (aclk),
    .areset_n    (areset_n),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .loop_i      (loop_i),
    .base_i      (base_i),
    .len_i       (len_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .mem_adr_o   (mem_adr_o),
    .mem_rd_o    (mem_rd_o),
    .mem_dat_i   (mem_dat_i),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tdata     (m_tdata),
    .m_tlast     (m_tlast),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- clock ----------------
  initial forever #5 aclk = ~aclk;

  // ---------------- SRAM model ----------------
  function automatic logic [DW-1:0] f(input logic [AW-1:0] a);
    return a[7:0] ^ 8'hC3 ^ {6'b000000, a[9:8]};
  endfunction

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] mem_q = '0;
  always @(posedge aclk) if (mem_rd_o) mem_q <= mem[mem_adr_o];
  assign mem_dat_i = mem_q;

  // ---------------- scoreboard state ----------------
  logic [DW:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int beat_cnt, first_cyc, last_cyc, done_cnt, done_cyc, first_rd_cyc;
  logic [DW-1:0] first_dat, last_dat;
  logic busy_seen, rd_seen, busy_at_done;
  logic [AW-1:0] adr_base;
  int adr_len, adr_idx;
  logic adr_loop;
  logic bp_mode = 1'b0;
  int out_cnt;
  logic prev_stall = 1'b0;
  logic prev_rd = 1'b0;
  logic [DW:0] prev_beat = '0;

  typedef struct {
    logic [AW-1:0] base;
    int            len;
    int            lat;
    logic [DW-1:0] first_dat;
    logic [DW-1:0] last_dat;
  } vec_t;
  vec_t vecs [0:4];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // ---------------- monitor (negedge sampling) ----------------
  task automatic monitor_loop();
    logic [AW-1:0] ea;
    int occ;
    logic pop;
    forever begin
      @(negedge aclk);
      pop = m_tvalid && m_tready;
      if (mem_rd_o) begin
        rd_seen = 1'b1;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        ea = adr_base + AW'(adr_idx);
        chk("mem_adr_o", int'(mem_adr_o), int'(ea));
        adr_idx++;
        if (adr_loop && adr_idx >= adr_len) adr_idx = 0;
      end
      if (bp_mode) begin
        occ = out_cnt - int'(prev_rd);
        if (occ == 2 && !pop) chk("rd_when_full", int'(mem_rd_o), 0);
        if (prev_stall) begin
          chk("stall_valid", int'(m_tvalid), 1);
          chk("stall_data", int'({m_tlast, m_tdata}), int'(prev_beat));
        end
        out_cnt = out_cnt + int'(mem_rd_o) - int'(pop);
        chk("outstanding_le_2", int'(out_cnt <= 2), 1);
      end
      if (pop) begin
        beat_cnt++;
        if (first_cyc < 0) begin
          first_cyc = cyc;
          first_dat = m_tdata;
        end
        last_cyc = cyc;
        last_dat = m_tdata;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL beat_unexpected: got beat 0x%0h, required none (cycle %0d)",
                   {m_tlast, m_tdata}, cyc);
        end else begin
          chk("beat", int'({m_tlast, m_tdata}), int'(exp_q.pop_front()));
        end
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
        busy_at_done = busy_o;
      end
      if (busy_o) busy_seen = 1'b1;
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = {m_tlast, m_tdata};
      prev_rd    = mem_rd_o;
    end
  endtask

  // Clear statistics, load the expected stream, pulse start; returns edge N
  task automatic start_run(input logic [AW-1:0] base, input int len, input logic lp,
                           input int npush, output int n);
    int idx;
    exp_q.delete();
    for (int k = 0; k < npush; k++) begin
      idx = lp ? (k % len) : k;
      exp_q.push_back({(idx == len - 1), f(base + AW'(idx))});
    end
    beat_cnt = 0; first_cyc = -1; last_cyc = -1; done_cnt = 0; done_cyc = -1;
    first_rd_cyc = -1; busy_seen = 1'b0; rd_seen = 1'b0; busy_at_done = 1'b1;
    first_dat = '0; last_dat = '0;
    adr_base = base; adr_len = len; adr_idx = 0; adr_loop = lp; out_cnt = 0;
    start_i = 1'b1; base_i = base; len_i = (AW+1)'(len); loop_i = lp;
    tick();
    n = cyc;
    start_i = 1'b0; loop_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input logic rand_rdy);
    int k;
    k = 0;
    while (done_cnt == 0 && k < budget) begin
      if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    chk("done_within_budget", int'(done_cnt != 0), 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int k;
    for (int i = 0; i < (1 << AW); i++) mem[i] = f(AW'(i));

    vecs[0] = '{base: 10'h3FE, len: 4,    lat: 6,    first_dat: 8'h3E, last_dat: 8'hC2};
    vecs[1] = '{base: 10'h000, len: 1,    lat: 3,    first_dat: 8'hC3, last_dat: 8'hC3};
    vecs[2] = '{base: 10'h155, len: 5,    lat: 7,    first_dat: 8'h97, last_dat: 8'h9B};
    vecs[3] = '{base: 10'h3FF, len: 2,    lat: 4,    first_dat: 8'h3F, last_dat: 8'hC3};
    vecs[4] = '{base: 10'h200, len: 1024, lat: 1026, first_dat: 8'hC1, last_dat: 8'h3D};

    beat_cnt = 0; first_cyc = -1; last_cyc = -1; done_cnt = 0; done_cyc = -1;
    first_rd_cyc = -1; busy_seen = 0; rd_seen = 0; busy_at_done = 0;
    adr_base = '0; adr_len = 0; adr_idx = 0; adr_loop = 0; out_cnt = 0;

    fork
      monitor_loop();
      forever begin
        @(posedge aclk);
        cyc++;
      end
    join_none

    // ---- reset ----
    areset_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; loop_i = 1'b0;
    base_i = '0; len_i = '0; m_tready = 1'b0;
    repeat (3) tick();
    @(negedge aclk);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_rd", int'(mem_rd_o), 0);
    chk("rst_tvalid", int'(m_tvalid), 0);
    chk("rst_tlast", int'(m_tlast), 0);
    chk("rst_adr", int'(mem_adr_o), 0);
    chk("rst_tdata", int'(m_tdata), 0);
    chk("rst_state", int'(dbg_state_o), 0);
    areset_n = 1'b1;
    tick();

    // ---- table of non-loop runs, sink always ready ----
    m_tready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      start_run(vecs[v].base, vecs[v].len, 1'b0, vecs[v].len, n);
      wait_done(vecs[v].len + 20, 1'b0);
      repeat (3) tick();
      chk("tbl_beats", beat_cnt, vecs[v].len);
      chk("tbl_done_cnt", done_cnt, 1);
      chk("tbl_done_lat", done_cyc - n, vecs[v].lat);
      chk("tbl_first_rd_lat", first_rd_cyc - n, 0);
      chk("tbl_first_beat_lat", first_cyc - n, 2);
      chk("tbl_back_to_back", last_cyc - first_cyc, vecs[v].len - 1);
      chk("tbl_first_dat", int'(first_dat), int'(vecs[v].first_dat));
      chk("tbl_last_dat", int'(last_dat), int'(vecs[v].last_dat));
      chk("tbl_busy_seen", int'(busy_seen), 1);
      chk("tbl_busy_at_done", int'(busy_at_done), 0);
      chk("tbl_busy_after", int'(busy_o), 0);
      chk("tbl_state_after", int'(dbg_state_o), 0);
      chk("tbl_exp_left", exp_q.size(), 0);
    end

    // ---- zero length ----
    start_run(10'h123, 0, 1'b0, 0, n);
    repeat (4) tick();
    chk("zero_done_cnt", done_cnt, 1);
    chk("zero_done_lat", done_cyc - n, 0);
    chk("zero_busy_seen", int'(busy_seen), 0);
    chk("zero_rd_seen", int'(rd_seen), 0);
    chk("zero_beats", beat_cnt, 0);

    // ---- backpressure, sink ready about half the time ----
    bp_mode = 1'b1;
    start_run(10'h1F8, 16, 1'b0, 16, n);
    wait_done(600, 1'b1);
    m_tready = 1'b1;
    repeat (3) tick();
    bp_mode = 1'b0;
    chk("bp_beats", beat_cnt, 16);
    chk("bp_done_cnt", done_cnt, 1);
    chk("bp_exp_left", exp_q.size(), 0);
    chk("bp_busy_after", int'(busy_o), 0);

    // ---- loop mode, abort after 10 beats ----
    start_run(10'h010, 3, 1'b1, 15, n);
    k = 0;
    while (beat_cnt < 10 && k < 100) begin
      @(negedge aclk);
      #1;
      k++;
    end
    chk("loop_reached_10", int'(beat_cnt >= 10), 1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    exp_q.delete();
    @(negedge aclk);
    chk("abort_tvalid", int'(m_tvalid), 0);
    chk("abort_busy", int'(busy_o), 0);
    chk("abort_state", int'(dbg_state_o), 0);
    repeat (5) tick();
    chk("loop_beats", beat_cnt, 10);
    chk("loop_no_done", done_cnt, 0);
    chk("loop_rd_after_abort", int'(mem_rd_o), 0);

    // ---- start while busy is ignored ----
    start_run(10'h020, 8, 1'b0, 8, n);
    repeat (3) tick();
    start_i = 1'b1; base_i = 10'h100; len_i = 11'd5;
    tick();
    start_i = 1'b0;
    wait_done(40, 1'b0);
    repeat (3) tick();
    chk("busy_start_beats", beat_cnt, 8);
    chk("busy_start_done_cnt", done_cnt, 1);
    chk("busy_start_lat", done_cyc - n, 10);
    chk("busy_start_last_dat", int'(last_dat), 8'hE4);
    chk("busy_start_exp_left", exp_q.size(), 0);

    // ---- reset mid-run with a stalled sink ----
    m_tready = 1'b0;
    start_run(10'h030, 8, 1'b0, 8, n);
    repeat (5) tick();
    areset_n = 1'b0;
    tick();
    @(negedge aclk);
    chk("mid_rst_busy", int'(busy_o), 0);
    chk("mid_rst_done", int'(done_o), 0);
    chk("mid_rst_rd", int'(mem_rd_o), 0);
    chk("mid_rst_tvalid", int'(m_tvalid), 0);
    chk("mid_rst_tlast", int'(m_tlast), 0);
    chk("mid_rst_adr", int'(mem_adr_o), 0);
    chk("mid_rst_tdata", int'(m_tdata), 0);
    chk("mid_rst_state", int'(dbg_state_o), 0);
    areset_n = 1'b1;
    exp_q.delete();
    tick();
    chk("mid_rst_no_done", done_cnt, 0);
    m_tready = 1'b1;
    start_run(10'h050, 2, 1'b0, 2, n);
    wait_done(20, 1'b0);
    repeat (3) tick();
    chk("post_rst_beats", beat_cnt, 2);
    chk("post_rst_done_cnt", done_cnt, 1);
    chk("post_rst_first_dat", int'(first_dat), 8'h93);
    chk("post_rst_last_dat", int'(last_dat), 8'h92);
    chk("post_rst_exp_left", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
